bus_arbiter: RTL and testbench

- Shares one 32-bit memory bus between two requesters: the instruction-fetch port (pc_reg / if_id side) and the data port (mem stage loads and stores).
- Sequences each transaction with a small FSM and enforces a wait-state timeout.
- Returns registered read data and a one-cycle ack to the winning requester.
- Drives a 6-bit pipeline stall vector so the openmips core freezes while either port waits.

---
 rtl/bus_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Shares one 32-bit memory bus between the instruction-fetch port and the
// data (load/store) port of the openmips core. A small FSM owns the bus for
// one transaction at a time, aborts a transaction that waits too long, and
// hands registered read data plus a one-cycle ack back to the requester that
// won arbitration. A stall vector freezes the pipeline while either port is
// waiting.
//
// Parameters
//   TIMEOUT  bus wait cycles before abort (0 = never abort)
//   CNT_W    wait counter width, 2**CNT_W > TIMEOUT
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr            fetch request and address
//   if_rdata/if_ack           fetched word (registered), 1-cycle completion
//   mem_req/we/addr/wdata/sel data request (we=1 store), address, data, byte enables
//   mem_rdata/mem_ack         load data (registered), 1-cycle completion
//   bus_req/we/addr/wdata/sel shared-bus request and registered command
//   bus_ack/bus_rdata         slave completion and read data
//   bus_err                   timeout abort, pulses together with the abort ack
//   stall[5:0]                {WB, MEM, EX, ID, IF, pc} freeze vector
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,

  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,

  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,

  output logic [5:0]  stall
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_FETCH,
    GNT_DATA
  } grant_t;

  // Counter value on the last permitted wait cycle.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  localparam logic [5:0] STALL_DATA  = 6'b011111;
  localparam logic [5:0] STALL_FETCH = 6'b000111;

  state_t           state;
  state_t           state_nxt;
  grant_t           grant;
  grant_t           grant_nxt;
  logic [CNT_W-1:0] cnt;
  logic             abort_q;
  logic             timeout_hit;
  logic             resp_fetch;
  logic             resp_data;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= GNT_NONE;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Data wins a tie because it belongs to the older
  // instruction. RESP always returns to IDLE so a request that is still high
  // from the finished transaction is not granted a second time.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          state_nxt = DATA;
          grant_nxt = GNT_DATA;
        end else if (if_req) begin
          state_nxt = FETCH;
          grant_nxt = GNT_FETCH;
        end
      end
      FETCH, DATA: begin
        timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
        if (bus_ack || timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        grant_nxt = GNT_NONE;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = GNT_NONE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: bus command latch on grant, wait counter, read-data capture.
  // An ack in the same cycle as the timeout takes priority over the abort.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      abort_q   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_sel   <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          abort_q <= 1'b0;
          if (mem_req) begin
            bus_addr  <= mem_addr;
            bus_we    <= mem_we;
            bus_sel   <= mem_sel;
            bus_wdata <= mem_wdata;
          end else if (if_req) begin
            bus_addr  <= if_addr;
            bus_we    <= 1'b0;
            bus_sel   <= '1;
            bus_wdata <= '0;
          end
        end
        FETCH, DATA: begin
          if (bus_ack) begin
            abort_q <= 1'b0;
            if (state == FETCH) begin
              if_rdata <= bus_rdata;
            end else if (!bus_we) begin
              mem_rdata <= bus_rdata;
            end
          end else if (timeout_hit) begin
            abort_q <= 1'b1;
            if (state == FETCH) begin
              if_rdata <= '0;
            end else begin
              mem_rdata <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          abort_q <= 1'b0;
        end
        default: begin
          abort_q <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. A port stops stalling in its own RESP cycle, where its ack is
  // presented; the other port keeps stalling if it is still requesting.
  // -------------------------------------------------------------------------
  always_comb begin
    resp_fetch = (state == RESP) && (grant == GNT_FETCH);
    resp_data  = (state == RESP) && (grant == GNT_DATA);

    bus_req = (state == FETCH) || (state == DATA);
    if_ack  = resp_fetch;
    mem_ack = resp_data;
    bus_err = (state == RESP) && abort_q;

    stall = '0;
    if (rst) begin
      stall = '0;
    end else if (mem_req && !resp_data) begin
      stall = STALL_DATA;
    end else if (if_req && !resp_fetch) begin
      stall = STALL_FETCH;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic [5:0]  stall;

  bus_arbiter #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_sel   (mem_sel),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_sel   (bus_sel),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .bus_err   (bus_err),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        ifr;
    logic [31:0] ifa;
    logic        mr;
    logic        mwe;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic [3:0]  msel;
    logic        ack;
    logic [31:0] rd;
  } in_t;

  typedef struct packed {
    logic        breq;
    logic        bwe;
    logic [31:0] baddr;
    logic [3:0]  bsel;
    logic [31:0] bwd;
    logic        iack;
    logic [31:0] ird;
    logic        mack;
    logic [31:0] mrd;
    logic        err;
    logic [5:0]  stall;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } row_t;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  in_t         cur;
  bit          model_on = 1'b0;
  row_t        tbl [16];

  // Reference model: phase 0 = bus free, 1 = transaction on the bus,
  // 2 = response cycle; owner 1 = fetch, 2 = data.
  int unsigned m_phase  = 0;
  int unsigned m_owner  = 0;
  int unsigned m_onbus  = 0;
  bit          m_err    = 1'b0;
  bit          m_zeroed = 1'b1;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_wdata  = '0;
  logic [31:0] m_ird    = '0;
  logic [31:0] m_mrd    = '0;
  logic        m_we     = 1'b0;
  logic [3:0]  m_sel    = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_check();
    logic [5:0] st;
    if (cur.rst) st = 6'b000000;
    else if (cur.mr && !(m_phase == 2 && m_owner == 2)) st = 6'b011111;
    else if (cur.ifr && !(m_phase == 2 && m_owner == 1)) st = 6'b000111;
    else st = 6'b000000;
    chk("rnd_stall",   32'(stall),   32'(st));
    chk("rnd_bus_req", 32'(bus_req), 32'(m_phase == 1));
    chk("rnd_if_ack",  32'(if_ack),  32'(m_phase == 2 && m_owner == 1));
    chk("rnd_mem_ack", 32'(mem_ack), 32'(m_phase == 2 && m_owner == 2));
    chk("rnd_bus_err", 32'(bus_err), 32'(m_phase == 2 && m_err));
    chk("rnd_if_rdata",  if_rdata,  m_ird);
    chk("rnd_mem_rdata", mem_rdata, m_mrd);
    if (m_phase == 1 || m_zeroed) begin
      chk("rnd_bus_addr",  bus_addr,        m_addr);
      chk("rnd_bus_we",    32'(bus_we),     32'(m_we));
      chk("rnd_bus_wdata", bus_wdata,       m_wdata);
      chk("rnd_bus_sel",   32'(bus_sel),    32'(m_sel));
    end
  endtask

  task automatic model_step();
    if (cur.rst) begin
      m_phase = 0; m_owner = 0; m_onbus = 0; m_err = 1'b0; m_zeroed = 1'b1;
      m_addr = '0; m_we = 1'b0; m_wdata = '0; m_sel = '0; m_ird = '0; m_mrd = '0;
    end else if (m_phase == 0) begin
      if (cur.mr) begin
        m_owner = 2; m_phase = 1; m_onbus = 1; m_zeroed = 1'b0;
        m_addr = cur.ma; m_we = cur.mwe; m_wdata = cur.mwd; m_sel = cur.msel;
      end else if (cur.ifr) begin
        m_owner = 1; m_phase = 1; m_onbus = 1; m_zeroed = 1'b0;
        m_addr = cur.ifa; m_we = 1'b0; m_wdata = '0; m_sel = 4'hF;
      end
    end else if (m_phase == 1) begin
      if (cur.ack) begin
        m_phase = 2; m_err = 1'b0;
        if (m_owner == 1) m_ird = cur.rd;
        else if (!m_we) m_mrd = cur.rd;
      end else if (TO != 0 && m_onbus == TO) begin
        m_phase = 2; m_err = 1'b1;
        if (m_owner == 1) m_ird = '0;
        else m_mrd = '0;
      end else begin
        m_onbus++;
      end
    end else begin
      m_phase = 0; m_owner = 0; m_err = 1'b0;
    end
  endtask

  task automatic apply();
    rst       = cur.rst;
    if_req    = cur.ifr;
    if_addr   = cur.ifa;
    mem_req   = cur.mr;
    mem_we    = cur.mwe;
    mem_addr  = cur.ma;
    mem_wdata = cur.mwd;
    mem_sel   = cur.msel;
    bus_ack   = cur.ack;
    bus_rdata = cur.rd;
    #1;
    if (model_on) model_check();
  endtask

  task automatic finish_cycle();
    model_step();
    @(negedge clk);
  endtask

  task automatic tick();
    apply();
    finish_cycle();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;

    // Single fetch, then simultaneous store+fetch, then a stray ack in IDLE.
    tbl[0].i  = '{default:'0};
    tbl[0].e  = '{default:'0};
    tbl[1].i  = '{ifr:1'b1, ifa:32'h10, default:'0};
    tbl[1].e  = '{stall:6'b000111, default:'0};
    tbl[2].i  = '{ifr:1'b1, ifa:32'h10, default:'0};
    tbl[2].e  = '{breq:1'b1, baddr:32'h10, bsel:4'hF, stall:6'b000111, default:'0};
    tbl[3].i  = '{ifr:1'b1, ifa:32'h10, default:'0};
    tbl[3].e  = '{breq:1'b1, baddr:32'h10, bsel:4'hF, stall:6'b000111, default:'0};
    tbl[4].i  = '{ifr:1'b1, ifa:32'h10, ack:1'b1, rd:32'h3421_0020, default:'0};
    tbl[4].e  = '{breq:1'b1, baddr:32'h10, bsel:4'hF, stall:6'b000111, default:'0};
    tbl[5].i  = '{ifr:1'b1, ifa:32'h10, default:'0};
    tbl[5].e  = '{iack:1'b1, ird:32'h3421_0020, default:'0};
    tbl[6].i  = '{default:'0};
    tbl[6].e  = '{ird:32'h3421_0020, default:'0};
    tbl[7].i  = '{ifr:1'b1, ifa:32'h20, mr:1'b1, mwe:1'b1, ma:32'h100, mwd:32'hDEAD_BEEF, msel:4'b0011, default:'0};
    tbl[7].e  = '{ird:32'h3421_0020, stall:6'b011111, default:'0};
    tbl[8].i  = '{ifr:1'b1, ifa:32'h20, mr:1'b1, mwe:1'b1, ma:32'h100, mwd:32'hDEAD_BEEF, msel:4'b0011, default:'0};
    tbl[8].e  = '{breq:1'b1, bwe:1'b1, baddr:32'h100, bsel:4'b0011, bwd:32'hDEAD_BEEF, ird:32'h3421_0020, stall:6'b011111, default:'0};
    tbl[9].i  = '{ifr:1'b1, ifa:32'h20, mr:1'b1, mwe:1'b1, ma:32'h100, mwd:32'hDEAD_BEEF, msel:4'b0011, ack:1'b1, rd:32'h5555_5555, default:'0};
    tbl[9].e  = '{breq:1'b1, bwe:1'b1, baddr:32'h100, bsel:4'b0011, bwd:32'hDEAD_BEEF, ird:32'h3421_0020, stall:6'b011111, default:'0};
    tbl[10].i = '{ifr:1'b1, ifa:32'h20, mr:1'b1, mwe:1'b1, ma:32'h100, mwd:32'hDEAD_BEEF, msel:4'b0011, default:'0};
    tbl[10].e = '{mack:1'b1, ird:32'h3421_0020, stall:6'b000111, default:'0};
    tbl[11].i = '{ifr:1'b1, ifa:32'h20, default:'0};
    tbl[11].e = '{ird:32'h3421_0020, stall:6'b000111, default:'0};
    tbl[12].i = '{ifr:1'b1, ifa:32'h20, ack:1'b1, rd:32'h8C22_0004, default:'0};
    tbl[12].e = '{breq:1'b1, baddr:32'h20, bsel:4'hF, ird:32'h3421_0020, stall:6'b000111, default:'0};
    tbl[13].i = '{default:'0};
    tbl[13].e = '{iack:1'b1, ird:32'h8C22_0004, default:'0};
    tbl[14].i = '{ack:1'b1, rd:32'hFFFF_FFFF, default:'0};
    tbl[14].e = '{ird:32'h8C22_0004, default:'0};
    tbl[15].i = '{default:'0};
    tbl[15].e = '{ird:32'h8C22_0004, default:'0};

    cur = '0;
    @(negedge clk);
    cur.rst = 1'b1;
    tick();
    tick();

    for (int unsigned r = 0; r < 16; r++) begin
      cur = tbl[r].i;
      apply();
      chk($sformatf("tbl%0d_bus_req", r),   32'(bus_req),   32'(tbl[r].e.breq));
      chk($sformatf("tbl%0d_if_ack", r),    32'(if_ack),    32'(tbl[r].e.iack));
      chk($sformatf("tbl%0d_mem_ack", r),   32'(mem_ack),   32'(tbl[r].e.mack));
      chk($sformatf("tbl%0d_bus_err", r),   32'(bus_err),   32'(tbl[r].e.err));
      chk($sformatf("tbl%0d_stall", r),     32'(stall),     32'(tbl[r].e.stall));
      chk($sformatf("tbl%0d_if_rdata", r),  if_rdata,       tbl[r].e.ird);
      chk($sformatf("tbl%0d_mem_rdata", r), mem_rdata,      tbl[r].e.mrd);
      if (tbl[r].e.breq) begin
        chk($sformatf("tbl%0d_bus_addr", r),  bus_addr,      tbl[r].e.baddr);
        chk($sformatf("tbl%0d_bus_we", r),    32'(bus_we),   32'(tbl[r].e.bwe));
        chk($sformatf("tbl%0d_bus_sel", r),   32'(bus_sel),  32'(tbl[r].e.bsel));
        chk($sformatf("tbl%0d_bus_wdata", r), bus_wdata,     tbl[r].e.bwd);
      end
      finish_cycle();
    end

    // Timeout: the slave never answers a fetch.
    cur = '0; cur.ifr = 1'b1; cur.ifa = 32'h40;
    tick();
    n = 0;
    apply();
    while (bus_req === 1'b1 && n < 20) begin
      chk("to_addr", bus_addr, 32'h40);
      n++;
      finish_cycle();
      apply();
    end
    chk("to_len",      n,              32'd4);
    chk("to_if_ack",   32'(if_ack),    32'd1);
    chk("to_if_rdata", if_rdata,       32'h0);
    chk("to_bus_err",  32'(bus_err),   32'd1);
    chk("to_stall",    32'(stall),     32'd0);
    finish_cycle();
    cur.ifr = 1'b0;
    apply();
    chk("to_idle_req", 32'(bus_req), 32'd0);
    chk("to_idle_ack", 32'(if_ack),  32'd0);
    chk("to_idle_err", 32'(bus_err), 32'd0);
    finish_cycle();

    // Ack on the last permitted wait cycle beats the timeout.
    cur = '0; cur.ifr = 1'b1; cur.ifa = 32'h50;
    tick();
    repeat (3) begin
      apply();
      chk("last_wait_req", 32'(bus_req), 32'd1);
      finish_cycle();
    end
    cur.ack = 1'b1; cur.rd = 32'hA5A5_0F0F;
    apply();
    chk("last_ack_req", 32'(bus_req), 32'd1);
    finish_cycle();
    cur = '0;
    apply();
    chk("last_if_ack",   32'(if_ack),  32'd1);
    chk("last_bus_err",  32'(bus_err), 32'd0);
    chk("last_if_rdata", if_rdata,     32'hA5A5_0F0F);
    finish_cycle();

    // Reset in the middle of a store.
    cur = '0; cur.mr = 1'b1; cur.mwe = 1'b1; cur.ma = 32'h180; cur.mwd = 32'h1234_5678; cur.msel = 4'hF;
    tick();
    apply();
    chk("rst_pre_req", 32'(bus_req), 32'd1);
    finish_cycle();
    cur.rst = 1'b1;
    apply();
    chk("rst_stall", 32'(stall), 32'd0);
    finish_cycle();
    cur = '0;
    apply();
    chk("rst_bus_req",   32'(bus_req), 32'd0);
    chk("rst_mem_ack",   32'(mem_ack), 32'd0);
    chk("rst_bus_addr",  bus_addr,     32'h0);
    chk("rst_bus_we",    32'(bus_we),  32'd0);
    chk("rst_bus_wdata", bus_wdata,    32'h0);
    chk("rst_bus_sel",   32'(bus_sel), 32'd0);
    chk("rst_if_rdata",  if_rdata,     32'h0);
    chk("rst_mem_rdata", mem_rdata,    32'h0);
    chk("rst_bus_err",   32'(bus_err), 32'd0);
    finish_cycle();
    apply();
    chk("rst_no_ack", 32'(mem_ack), 32'd0);
    finish_cycle();
    cur.mr = 1'b1; cur.ma = 32'h200;
    tick();
    cur.ack = 1'b1; cur.rd = 32'hCAFE_F00D;
    apply();
    chk("post_rst_addr", bus_addr,    32'h200);
    chk("post_rst_we",   32'(bus_we), 32'd0);
    finish_cycle();
    cur = '0;
    apply();
    chk("post_rst_ack",   32'(mem_ack), 32'd1);
    chk("post_rst_rdata", mem_rdata,    32'hCAFE_F00D);
    finish_cycle();

    // Back-to-back loads with mem_req held through RESP.
    cur = '0; cur.mr = 1'b1; cur.ma = 32'h300;
    tick();
    cur.ack = 1'b1; cur.rd = 32'h1111_2222;
    apply();
    chk("b2b_addr0", bus_addr, 32'h300);
    finish_cycle();
    cur.ack = 1'b0;
    apply();
    chk("b2b_resp_req",   32'(bus_req), 32'd0);
    chk("b2b_resp_ack",   32'(mem_ack), 32'd1);
    chk("b2b_resp_rdata", mem_rdata,    32'h1111_2222);
    chk("b2b_resp_stall", 32'(stall),   32'd0);
    finish_cycle();
    cur.ma = 32'h304;
    apply();
    chk("b2b_idle_req",   32'(bus_req), 32'd0);
    chk("b2b_idle_ack",   32'(mem_ack), 32'd0);
    chk("b2b_idle_stall", 32'(stall),   32'(6'b011111));
    finish_cycle();
    apply();
    chk("b2b_req1",  32'(bus_req), 32'd1);
    chk("b2b_addr1", bus_addr,     32'h304);
    finish_cycle();
    cur.ack = 1'b1; cur.rd = 32'h3333_4444;
    tick();
    cur = '0;
    apply();
    chk("b2b_ack1",   32'(mem_ack), 32'd1);
    chk("b2b_rdata1", mem_rdata,    32'h3333_4444);
    finish_cycle();
    tick();

    // Randomized traffic against the reference model.
    model_on = 1'b1;
    repeat (4000) begin
      cur.rst  = ($urandom_range(99) == 0);
      cur.ifr  = 1'($urandom_range(1));
      cur.ifa  = $urandom;
      cur.mr   = ($urandom_range(2) == 0);
      cur.mwe  = 1'($urandom_range(1));
      cur.ma   = $urandom;
      cur.mwd  = $urandom;
      cur.msel = 4'($urandom);
      cur.ack  = ($urandom_range(3) == 0);
      cur.rd   = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
